// File: rtl/audio_frame_scheduler.sv
// Stereo audio frame pacer: fractional phase accumulator ticks, source capture, two-beat AXIS output.
// Optional overrun_count output enabled by defining AUDIO_SCHED_OVERRUN_CNT_EN.
module audio_frame_scheduler #(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned SEL_W          = 2,
    parameter int unsigned AUDIO_IN_DW    = 12,
    parameter int unsigned AUDIO_OUT_DW   = 32,
    parameter int unsigned AUDIO_BIT_RATE = 24,
    parameter int unsigned ACC_W          = 24
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ACC_W-1:0]                tick_inc,
    input  logic [SEL_W-1:0]                src_sel,
    input  logic [NUM_SRC*AUDIO_IN_DW-1:0]  src_left,
    input  logic [NUM_SRC*AUDIO_IN_DW-1:0]  src_right,
    output logic [AUDIO_OUT_DW-1:0]         axis_data,
    output logic                            axis_valid,
    output logic                            axis_last,
    input  logic                            axis_ready,
    output logic                            sample_tick,
    output logic                            overrun,
`ifdef AUDIO_SCHED_OVERRUN_CNT_EN
    output logic [15:0]                     overrun_count,
`endif
    output logic                            busy
);

    localparam int unsigned SHIFT = AUDIO_BIT_RATE - AUDIO_IN_DW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ACC_W-1:0]         r_acc;
    logic [ACC_W:0]           w_sum;
    logic                     r_tick;
    logic [AUDIO_IN_DW-1:0]   r_right;
    logic [AUDIO_OUT_DW-1:0]  r_data;
    logic [AUDIO_OUT_DW-1:0]  w_data_nxt;
    logic                     r_valid;
    logic                     r_last;
    logic                     r_busy;
    logic                     r_ovr;
    logic                     w_ovr_nxt;
    logic                     w_latch;
    logic [AUDIO_IN_DW-1:0]   w_sel_left;
    logic [AUDIO_IN_DW-1:0]   w_sel_right;

    // Place the sample just below AUDIO_BIT_RATE, zero-filled above and below.
    function automatic logic [AUDIO_OUT_DW-1:0] fmt(input logic [AUDIO_IN_DW-1:0] s);
        return AUDIO_OUT_DW'(s) << SHIFT;
    endfunction

    assign w_sum = {1'b0, r_acc} + {1'b0, tick_inc};

    // Source mux; out-of-range selects read as silence.
    always_comb begin
        w_sel_left  = '0;
        w_sel_right = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                w_sel_left  = src_left[i*AUDIO_IN_DW +: AUDIO_IN_DW];
                w_sel_right = src_right[i*AUDIO_IN_DW +: AUDIO_IN_DW];
            end
        end
    end

    // Next-state and next-output logic; a tick is accepted only when no frame remains in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_ovr_nxt   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_data_nxt = '0;
                if (r_tick) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (r_tick) begin
                    w_ovr_nxt = 1'b1;
                end
                if (axis_ready) begin
                    w_state_nxt = ST_RIGHT;
                    w_data_nxt  = fmt(r_right);
                end
            end
            ST_RIGHT: begin
                if (axis_ready) begin
                    if (r_tick) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_LEFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_data_nxt  = '0;
                    end
                end else if (r_tick) begin
                    w_ovr_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_data_nxt  = '0;
            end
        endcase
        if (w_latch) begin
            w_data_nxt = fmt(w_sel_left);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_tick  <= 1'b0;
            r_state <= ST_IDLE;
            r_right <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_tick  <= w_sum[ACC_W];
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_valid <= (w_state_nxt != ST_IDLE);
            r_last  <= (w_state_nxt == ST_RIGHT);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_ovr   <= w_ovr_nxt;
            if (w_latch) begin
                r_right <= w_sel_right;
            end
        end
    end

`ifdef AUDIO_SCHED_OVERRUN_CNT_EN
    logic [15:0] r_ovr_cnt;

    // Saturating count of dropped ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovr_cnt <= '0;
        end else if (r_ovr && (r_ovr_cnt != 16'hFFFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 16'd1;
        end
    end

    assign overrun_count = r_ovr_cnt;
`endif

    assign axis_data   = r_data;
    assign axis_valid  = r_valid;
    assign axis_last   = r_last;
    assign sample_tick = r_tick;
    assign overrun     = r_ovr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Self-checking bench for audio_frame_scheduler: queue-based frame model plus directed literal checks.
module tb_audio_frame_scheduler;

    localparam int unsigned NSRC = 3;
    localparam int unsigned IDW  = 12;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [23:0]       tick_inc;
    logic [1:0]        src_sel;
    logic [NSRC*IDW-1:0] src_left;
    logic [NSRC*IDW-1:0] src_right;
    logic [31:0]       axis_data;
    logic              axis_valid;
    logic              axis_last;
    logic              axis_ready;
    logic              sample_tick;
    logic              overrun;
    logic              busy;
`ifdef AUDIO_SCHED_OVERRUN_CNT_EN
    logic [15:0]       overrun_count;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    audio_frame_scheduler #(
        .NUM_SRC(NSRC), .SEL_W(2), .AUDIO_IN_DW(IDW),
        .AUDIO_OUT_DW(32), .AUDIO_BIT_RATE(24), .ACC_W(24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick_inc(tick_inc), .src_sel(src_sel),
        .src_left(src_left), .src_right(src_right), .axis_data(axis_data),
        .axis_valid(axis_valid), .axis_last(axis_last), .axis_ready(axis_ready),
        .sample_tick(sample_tick), .overrun(overrun),
`ifdef AUDIO_SCHED_OVERRUN_CNT_EN
        .overrun_count(overrun_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Output word for a source: sample shifted up by 24-12 bits, silence when the source is absent.
    function automatic logic [31:0] word_of(input logic [1:0] sel, input logic [NSRC*IDW-1:0] bus);
        int unsigned s;
        if (int'(sel) >= int'(NSRC)) return 32'h0;
        s = 32'((bus >> (IDW * sel)) & 36'hFFF);
        return 32'(s * 4096);
    endfunction

    // Model: pending beats queue; a tick starts a frame only if nothing remains after this cycle's handshake.
    typedef struct packed { logic [31:0] d; logic l; } beat_t;
    beat_t           q[$];
    longint unsigned m_acc = 0;
    bit              m_tick = 0;
    bit              m_ovr = 0;
    int unsigned     m_cnt = 0;
    bit              m_hs;
    bit              m_tk;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            q.delete();
            m_acc = 0; m_tick = 0; m_ovr = 0; m_cnt = 0;
        end else begin
            m_hs = (q.size() > 0) && axis_ready;
            m_tk = m_tick;
            if (m_hs) void'(q.pop_front());
            m_ovr = 0;
            if (m_tk) begin
                if (q.size() == 0) begin
                    q.push_back('{d: word_of(src_sel, src_left),  l: 1'b0});
                    q.push_back('{d: word_of(src_sel, src_right), l: 1'b1});
                end else begin
                    m_ovr = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            m_acc  = m_acc + 64'(tick_inc);
            m_tick = (m_acc >> 24) != 0;
            m_acc  = m_acc & 64'hFF_FFFF;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", 32'(axis_valid), 32'(q.size() > 0));
            chk("m_busy",  32'(busy),       32'(q.size() > 0));
            chk("m_data",  axis_data,       (q.size() > 0) ? q[0].d : 32'h0);
            chk("m_last",  32'(axis_last),  (q.size() > 0) ? 32'(q[0].l) : 32'h0);
            chk("m_tick",  32'(sample_tick), 32'(m_tick));
            chk("m_ovr",   32'(overrun),    32'(m_ovr));
`ifdef AUDIO_SCHED_OVERRUN_CNT_EN
            chk("m_ovr_cnt", 32'(overrun_count), m_cnt);
`endif
        end
    end

    task automatic wait_tick(input int budget);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!sample_tick && i < budget);
        chk("tick_wait", 32'(sample_tick), 32'd1);
    endtask

    initial begin
        int n, nv, hs;
        reset_n = 1'b0; tick_inc = '0; src_sel = '0;
        src_left = '0; src_right = '0; axis_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(axis_valid), 32'd0);
        chk("rst_data",  axis_data, 32'd0);
        chk("rst_tick",  32'(sample_tick), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // tick_inc = 0 never ticks
        n = 0;
        repeat (30) begin @(negedge clk); if (sample_tick) n++; end
        chk("inc0_no_tick", n, 0);

        // source 2, nominal streaming
        src_sel = 2'd2;
        src_left[24 +: 12]  = 12'hABC;
        src_right[24 +: 12] = 12'h123;
        tick_inc = 24'h100000;
        wait_tick(40);
        @(negedge clk);
        chk("s2_left_valid", 32'(axis_valid), 32'd1);
        chk("s2_left_data",  axis_data, 32'h00ABC000);
        chk("s2_left_last",  32'(axis_last), 32'd0);
        @(negedge clk);
        chk("s2_right_data", axis_data, 32'h00123000);
        chk("s2_right_last", 32'(axis_last), 32'd1);
        @(negedge clk);
        chk("s2_idle_valid", 32'(axis_valid), 32'd0);
        wait_tick(40);
        n = 0;
        do begin @(negedge clk); n++; end while (!sample_tick && n < 100);
        chk("tick_period", n, 16);

        // out-of-range source gives silence
        src_sel = 2'd3;
        wait_tick(40);
        @(negedge clk);
        chk("s3_left_valid", 32'(axis_valid), 32'd1);
        chk("s3_left_data",  axis_data, 32'h0);
        @(negedge clk);
        chk("s3_right_data", axis_data, 32'h0);
        chk("s3_right_last", 32'(axis_last), 32'd1);

        // sink stall across two ticks
        src_sel = 2'd2;
        wait_tick(40);
        axis_ready = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (overrun) n++;
            chk("stall_hold_data", axis_data, 32'h00ABC000);
            chk("stall_hold_last", 32'(axis_last), 32'd0);
        end
        chk("stall_ovr_pulses", n, 2);
`ifdef AUDIO_SCHED_OVERRUN_CNT_EN
        chk("stall_ovr_count", 32'(overrun_count), 32'd2);
`endif
        axis_ready = 1'b1;
        hs = 0; n = 0;
        do begin
            if (axis_valid && axis_ready) hs++;
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 30);
        chk("stall_one_frame", hs, 2);

        // tick coincident with the right-beat handshake
        src_sel = 2'd0;
        src_left[0 +: 12]  = 12'h111;
        src_right[0 +: 12] = 12'h222;
        tick_inc = 24'h800000;
        repeat (10) @(negedge clk);
        wait_tick(10);
        @(negedge clk);
        chk("bb_left_data", axis_data, 32'h00111000);
        chk("bb_left_last", 32'(axis_last), 32'd0);
        src_left[0 +: 12]  = 12'h333;
        src_right[0 +: 12] = 12'h444;
        @(negedge clk);
        chk("bb_right_data", axis_data, 32'h00222000);
        chk("bb_right_last", 32'(axis_last), 32'd1);
        @(negedge clk);
        chk("bb_next_valid", 32'(axis_valid), 32'd1);
        chk("bb_next_data",  axis_data, 32'h00333000);
        chk("bb_next_last",  32'(axis_last), 32'd0);
        chk("bb_no_ovr",     32'(overrun), 32'd0);
        @(negedge clk);
        chk("bb_next_right", axis_data, 32'h00444000);

        // reset during the left beat
        src_sel = 2'd2;
        tick_inc = 24'h100000;
        repeat (20) @(negedge clk);
        wait_tick(40);
        axis_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(axis_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(axis_valid), 32'd0);
        chk("rst_mid_data",  axis_data, 32'd0);
        chk("rst_mid_busy",  32'(busy), 32'd0);
        chk("rst_mid_last",  32'(axis_last), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        axis_ready = 1'b1;
        n = 0; nv = 0;
        do begin
            @(negedge clk);
            n++;
            if (axis_valid) nv++;
        end while (!sample_tick && n < 40);
        chk("post_rst_no_beat", nv, 0);
        chk("post_rst_tick_at", n, 16);
        @(negedge clk);
        chk("post_rst_valid", 32'(axis_valid), 32'd1);
        chk("post_rst_data",  axis_data, 32'h00ABC000);
        repeat (4) @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/audio_frame_scheduler.md
Name: audio_frame_scheduler

Overview:
- Paces stereo audio frames onto the AXI-Stream audio path at a programmable sample rate, generated by a fractional phase accumulator.
- On each sample tick, captures the left/right pair from one of NUM_SRC sources and formats it into the output word.
- Emits left then right as two beats, with axis_last on the right beat, and flags overruns when the downstream sink stalls past the next tick.
- Sits between the audio sources (DAC/mixer side) and the codec/I2S AXIS sink.

Parameters:
- NUM_SRC, 4, number of selectable stereo sources (at least 1).
- SEL_W, 2, width of src_sel; must satisfy 2^SEL_W >= NUM_SRC.
- AUDIO_IN_DW, 12, source sample width.
- AUDIO_OUT_DW, 32, AXIS data width.
- AUDIO_BIT_RATE, 24, MSB+1 position of the sample inside the output word; AUDIO_IN_DW <= AUDIO_BIT_RATE <= AUDIO_OUT_DW.
- ACC_W, 24, phase accumulator width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- tick_inc  input  ACC_W  phase increment added every cycle; tick rate = f_clk*tick_inc/2^ACC_W.
- src_sel  input  SEL_W  source select; sampled only at a tick.
- src_left  input  NUM_SRC*AUDIO_IN_DW  packed left samples; source i occupies bits [i*AUDIO_IN_DW +: AUDIO_IN_DW].
- src_right  input  NUM_SRC*AUDIO_IN_DW  packed right samples, same packing.
- axis_data  output  AUDIO_OUT_DW  stream data.
- axis_valid  output  1  stream valid.
- axis_last  output  1  high on the right-channel beat.
- axis_ready  input  1  stream ready.
- sample_tick  output  1  one-cycle pulse on accumulator carry.
- overrun  output  1  one-cycle pulse when a tick is dropped.
- busy  output  1  high while a frame is in flight (state != IDLE).

Behaviour:
- Reset (reset_n low, asynchronous):
  - accumulator = 0, state = IDLE.
  - axis_data = 0; axis_valid, axis_last, sample_tick, overrun and busy = 0.
  - Latched samples cleared.
  - Reset mid-frame abandons the frame; no beat is emitted after reset deasserts until the next tick.
- Accumulator:
  - Each cycle, {carry, acc} <= acc + tick_inc, computed at ACC_W+1 bits.
  - carry=1 registers sample_tick=1 for exactly one cycle.
  - tick_inc=0 produces no ticks; the accumulator wraps modulo 2^ACC_W.
- Formatting: word = zeros in [AUDIO_OUT_DW-1:AUDIO_BIT_RATE], sample in [AUDIO_BIT_RATE-1:AUDIO_BIT_RATE-AUDIO_IN_DW], zeros below. There is no sign extension.
- Source select: if src_sel >= NUM_SRC, both samples latch as 0.
- State machine (IDLE, LEFT, RIGHT), all registered on the rising edge of clk:
  - IDLE, tick: latch left/right of src_sel; go to LEFT. axis_valid rises the cycle after sample_tick (latency 1).
  - LEFT: axis_valid=1, axis_last=0, axis_data=left word. On axis_ready, go to RIGHT.
  - RIGHT: axis_valid=1, axis_last=1, axis_data=right word. On axis_ready, go to IDLE, unless a tick occurs in the same cycle; then latch a new frame and go directly to LEFT with no overrun.
  - LEFT, or RIGHT without handshake, when a tick occurs: pulse overrun for one cycle. The tick is dropped and the current frame completes unchanged.
- AXIS rules:
  - axis_data and axis_last stay stable while axis_valid && !axis_ready.
  - axis_valid never drops before the handshake.
  - axis_ready while in IDLE is ignored.
- Source inputs and src_sel may change at any time; only values present at the accepted tick matter.

Optional Feature:
- Macro: AUDIO_SCHED_OVERRUN_CNT_EN.
- Defined: adds output overrun_count [15:0], incremented on every overrun pulse, saturating at 16'hFFFF and cleared by reset.
- Undefined: the port and counter are absent; the overrun pulse is unchanged.

Test Plan:
- ACC_W=24, tick_inc=24'h100000, axis_ready=1: sample_tick every 16 cycles. Each tick is followed by beats left (last=0) then right (last=1) on the next two cycles.
- src_sel=2, source 2 left=12'hABC, right=12'h123: axis_data=32'h00ABC000 then 32'h00123000 with last=1.
- src_sel=3 with NUM_SRC=3: both beats carry 32'h00000000.
- axis_ready=0 for 40 cycles with a tick every 16 cycles: left beat is held stable, overrun pulses twice, and overrun_count=2 when the macro is defined. After ready returns, exactly one frame is emitted.
- Tick coincident with the right-beat handshake: the next cycle is LEFT with new data and no overrun pulse.
- reset_n pulsed low during the LEFT beat: outputs go to 0 immediately, and the next valid appears only after a fresh tick.
